// File: rtl/scene_sequencer_pkg.sv
// Shared types and constants for the scene sequencer: scene codes, controller states
// and the darkest fade level.
package scene_sequencer_pkg;

  typedef enum logic [1:0] {
    SceneTitle = 2'd0,
    SceneGame  = 2'd1,
    SceneEnd   = 2'd2
  } scene_t;

  typedef enum logic [2:0] {
    StTitle,
    StGame,
    StFadeOut,
    StFadeIn,
    StEndShow,
    StEndReady
  } state_t;

  localparam logic [2:0] FADE_MAX = 3'd7;

endpackage

// File: rtl/frame_tick_counter.sv
// Modulo-N counter that advances on frame ticks. It pulses o_wrap on the tick that
// returns it to zero, and a synchronous clear holds it at zero.
module frame_tick_counter #(
  parameter int unsigned N = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_wrap
);

  localparam int unsigned W = $clog2(N) + 1;
  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_wrap = i_tick & ~i_clear & (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_tick) begin
      cnt_d = o_wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Screen controller for the VGA path. It selects the title, game or end frame, fades
// between them on frame ticks, and latches the winner for the end screen.
module scene_sequencer
  import scene_sequencer_pkg::*;
#(
  parameter int unsigned FADE_DIV       = 4,
  parameter int unsigned END_MIN_FRAMES = 180,
  parameter int unsigned BLINK_FRAMES   = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_start,
  input  logic       i_game_over,
  input  logic       i_p1_win,
  output logic [1:0] o_scene,
  output logic [2:0] o_fade,
  output logic       o_is_p1_win,
  output logic       o_game_en,
  output logic       o_blink,
  output logic       o_busy
);

  state_t     state_q, state_d;
  scene_t     target_q, target_d;
  scene_t     scene_q, scene_d;
  logic [2:0] fade_q, fade_d;
  logic       win_q, win_d;
  logic       game_en_q, game_en_d;
  logic       blink_q, blink_d;
  logic       busy_q, busy_d;
  logic       start_pend_q, start_pend_d;
  logic       over_pend_q, over_pend_d;

  logic in_fade, in_show, in_ready;
  logic start_ok, over_ok, start_evt, over_evt;
  logic div_wrap, hold_wrap, blink_wrap;

  assign in_fade   = (state_q == StFadeOut) || (state_q == StFadeIn);
  assign in_show   = (state_q == StEndShow);
  assign in_ready  = (state_q == StEndReady);
  assign start_ok  = (state_q == StTitle) || in_ready;
  assign over_ok   = (state_q == StGame);
  // A pulse arriving on the tick cycle itself counts as the event for that tick.
  assign start_evt = start_ok & (start_pend_q | i_start);
  assign over_evt  = over_ok & (over_pend_q | i_game_over);

  frame_tick_counter #(.N(FADE_DIV)) u_fade_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_frame_tick & in_fade),
    .i_clear (~in_fade),
    .o_wrap  (div_wrap)
  );

  frame_tick_counter #(.N(END_MIN_FRAMES)) u_end_hold (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_frame_tick & in_show),
    .i_clear (~in_show),
    .o_wrap  (hold_wrap)
  );

  frame_tick_counter #(.N(BLINK_FRAMES)) u_blink (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_frame_tick & in_ready),
    .i_clear (~in_ready),
    .o_wrap  (blink_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StTitle;
      target_q     <= SceneTitle;
      scene_q      <= SceneTitle;
      fade_q       <= '0;
      win_q        <= 1'b0;
      game_en_q    <= 1'b0;
      blink_q      <= 1'b0;
      busy_q       <= 1'b0;
      start_pend_q <= 1'b0;
      over_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      scene_q      <= scene_d;
      fade_q       <= fade_d;
      win_q        <= win_d;
      game_en_q    <= game_en_d;
      blink_q      <= blink_d;
      busy_q       <= busy_d;
      start_pend_q <= start_pend_d;
      over_pend_q  <= over_pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (i_frame_tick) begin
      unique case (state_q)
        StTitle: begin
          if (start_evt) begin
            state_d  = StFadeOut;
            target_d = SceneGame;
          end
        end
        StGame: begin
          if (over_evt) begin
            state_d  = StFadeOut;
            target_d = SceneEnd;
          end
        end
        StFadeOut: begin
          if (div_wrap && (fade_q == FADE_MAX)) state_d = StFadeIn;
        end
        StFadeIn: begin
          if (div_wrap && (fade_q == '0)) begin
            unique case (target_q)
              SceneGame: state_d = StGame;
              SceneEnd:  state_d = StEndShow;
              default:   state_d = StTitle;
            endcase
          end
        end
        StEndShow: begin
          if (hold_wrap) state_d = StEndReady;
        end
        StEndReady: begin
          if (start_evt) begin
            state_d  = StFadeOut;
            target_d = SceneTitle;
          end
        end
        default: state_d = StTitle;
      endcase
    end
  end

  always_comb begin
    scene_d      = scene_q;
    fade_d       = fade_q;
    win_d        = win_q;
    game_en_d    = (state_d == StGame);
    busy_d       = (state_d == StFadeOut) || (state_d == StFadeIn);
    start_pend_d = start_pend_q;
    over_pend_d  = over_pend_q;
    blink_d      = blink_q;

    // Every tick consumes whatever is pending; leaving a state also happens only on ticks.
    if (!start_ok || i_frame_tick) begin
      start_pend_d = 1'b0;
    end else if (i_start) begin
      start_pend_d = 1'b1;
    end
    if (!over_ok || i_frame_tick) begin
      over_pend_d = 1'b0;
    end else if (i_game_over) begin
      over_pend_d = 1'b1;
    end

    if (over_ok && i_game_over) win_d = i_p1_win;

    if ((state_q == StFadeOut) && div_wrap) begin
      if (fade_q == FADE_MAX) begin
        scene_d = target_q;
      end else begin
        fade_d = fade_q + 3'd1;
      end
    end
    if ((state_q == StFadeIn) && div_wrap && (fade_q != '0)) begin
      fade_d = fade_q - 3'd1;
    end

    if (state_d != StEndReady) begin
      blink_d = 1'b0;
    end else if (blink_wrap) begin
      blink_d = ~blink_q;
    end
  end

  assign o_scene     = scene_q;
  assign o_fade      = fade_q;
  assign o_is_p1_win = win_q;
  assign o_game_en   = game_en_q;
  assign o_blink     = blink_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: a directed vector table walking all scenes, a reset
// mid-fade sequence, and a randomized run against a tick-level reference model.
module tb_scene_sequencer;

  localparam int D  = 4;
  localparam int EM = 180;
  localparam int BF = 32;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic       i_start = 1'b0;
  logic       i_game_over = 1'b0;
  logic       i_p1_win = 1'b0;
  logic [1:0] o_scene;
  logic [2:0] o_fade;
  logic       o_is_p1_win;
  logic       o_game_en;
  logic       o_blink;
  logic       o_busy;

  int tests = 0;
  int fails = 0;

  scene_sequencer #(
    .FADE_DIV       (D),
    .END_MIN_FRAMES (EM),
    .BLINK_FRAMES   (BF)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_frame_tick (i_frame_tick),
    .i_start      (i_start),
    .i_game_over  (i_game_over),
    .i_p1_win     (i_p1_win),
    .o_scene      (o_scene),
    .o_fade       (o_fade),
    .o_is_p1_win  (o_is_p1_win),
    .o_game_en    (o_game_en),
    .o_blink      (o_blink),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: scene shown, whether a fade runs and how many ticks into it,
  // and how many ticks the end screen has been up.
  int m_scene, m_target, m_pos, m_end;
  bit m_fading, m_win, m_spend, m_opend;

  function automatic void model_reset();
    m_scene = 0; m_target = 0; m_pos = 0; m_end = 0;
    m_fading = 0; m_win = 0; m_spend = 0; m_opend = 0;
  endfunction

  function automatic logic [8:0] model_out();
    int  f;
    bit  ready, blink, en;
    logic [1:0] sc;
    logic [2:0] fv;
    if (!m_fading)         f = 0;
    else if (m_pos < 8*D)  f = m_pos / D;
    else                   f = 7 - (m_pos - 8*D) / D;
    ready = (m_scene == 2) && !m_fading && (m_end >= EM);
    blink = ready && ((((m_end - EM) / BF) % 2) == 1);
    en    = (m_scene == 1) && !m_fading;
    sc    = m_scene[1:0];
    fv    = f[2:0];
    return {sc, fv, m_win, en, blink, m_fading};
  endfunction

  function automatic void model_step(input bit t, input bit s, input bit o, input bit p);
    bit acc_s, acc_o;
    acc_s = !m_fading && ((m_scene == 0) || ((m_scene == 2) && (m_end >= EM)));
    acc_o = !m_fading && (m_scene == 1);
    if (acc_o && o) m_win = p;
    if (t) begin
      if (m_fading) begin
        m_pos++;
        if (m_pos == 8*D) m_scene = m_target;
        if (m_pos == 16*D) begin
          m_fading = 0;
          m_end    = 0;
        end
      end else if (acc_s && (m_spend || s)) begin
        m_fading = 1; m_pos = 0; m_target = (m_scene == 0) ? 1 : 0;
      end else if (acc_o && (m_opend || o)) begin
        m_fading = 1; m_pos = 0; m_target = 2;
      end else if (m_scene == 2) begin
        m_end++;
      end
      m_spend = 0;
      m_opend = 0;
    end else begin
      m_spend = acc_s && (m_spend || s);
      m_opend = acc_o && (m_opend || o);
    end
  endfunction

  function automatic logic [8:0] dut_out();
    return {o_scene, o_fade, o_is_p1_win, o_game_en, o_blink, o_busy};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = dut_out();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got scene=%0d fade=%0d win=%b en=%b blink=%b busy=%b, want scene=%0d fade=%0d win=%b en=%b blink=%b busy=%b",
               name, $time, got[8:7], got[6:4], got[3], got[2], got[1], got[0],
               exp[8:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input bit t, input bit s, input bit o, input bit p);
    i_frame_tick = t; i_start = s; i_game_over = o; i_p1_win = p;
    @(posedge i_clk);
    model_step(t, s, o, p);
    @(negedge i_clk);
    check("model", model_out());
  endtask

  typedef struct {
    bit t, s, o, p;
    int reps;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit t, input bit s, input bit o, input bit p, input int reps,
                              input int sc, input int fd, input bit w, input bit en,
                              input bit bl, input bit bz);
    vec_t v;
    logic [1:0] scv;
    logic [2:0] fdv;
    scv = sc[1:0];
    fdv = fd[2:0];
    v.t = t; v.s = s; v.o = o; v.p = p; v.reps = reps;
    v.exp = {scv, fdv, w, en, bl, bz};
    vecs.push_back(v);
  endfunction

  task automatic apply_reset();
    i_frame_tick = 0; i_start = 0; i_game_over = 0; i_p1_win = 0;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", 9'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    //   t s o p reps  scene fade win en blink busy
    add(0, 0, 0, 0,   1,  0, 0, 0, 0, 0, 0);  // idle title
    add(0, 1, 0, 0,   1,  0, 0, 0, 0, 0, 0);  // start pended
    add(1, 0, 0, 0,   1,  0, 0, 0, 0, 0, 1);  // tick consumes it
    add(1, 0, 0, 0,  28,  0, 7, 0, 0, 0, 1);
    add(1, 0, 0, 0,   3,  0, 7, 0, 0, 0, 1);
    add(1, 0, 0, 0,   1,  1, 7, 0, 0, 0, 1);  // black frame, scene switch
    add(1, 0, 0, 0,  31,  1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0,   1,  1, 0, 0, 1, 0, 0);  // game running
    add(0, 1, 0, 0,   1,  1, 0, 0, 1, 0, 0);  // start dropped in game
    add(1, 0, 0, 0,   1,  1, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1,   1,  1, 0, 1, 0, 0, 1);  // over on tick
    add(1, 0, 0, 0,  31,  1, 7, 1, 0, 0, 1);
    add(1, 0, 0, 0,   1,  2, 7, 1, 0, 0, 1);
    add(1, 0, 1, 0,  32,  2, 0, 1, 0, 0, 0);  // over ignored in fade-in
    add(0, 1, 0, 0,   1,  2, 0, 1, 0, 0, 0);  // start dropped in end show
    add(1, 0, 0, 0, 179,  2, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0,   1,  2, 0, 1, 0, 0, 0);  // now end ready
    add(1, 0, 0, 0,  31,  2, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0,   1,  2, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0,  32,  2, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0,   1,  2, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0,   1,  2, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0,  64,  0, 0, 1, 0, 0, 0);  // back to title, winner held
    add(1, 0, 1, 0,   1,  0, 0, 1, 0, 0, 0);  // over ignored in title
    add(1, 1, 0, 0,   1,  0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0,  64,  1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0,   1,  1, 0, 0, 1, 0, 0);  // winner relatched
    add(1, 0, 0, 0,   1,  1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0,  16,  1, 4, 0, 0, 0, 1);  // mid fade-out

    model_reset();
    repeat (2) @(negedge i_clk);
    check("reset_state", 9'b0);
    i_rst_n = 1'b1;

    foreach (vecs[k]) begin
      for (int r = 0; r < vecs[k].reps; r++) step(vecs[k].t, vecs[k].s, vecs[k].o, vecs[k].p);
      check($sformatf("vec%0d", k), vecs[k].exp);
    end

    apply_reset();
    check("after_release", 9'b0);

    for (int i = 0; i < 20000; i++) begin
      if (i == 9000) apply_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Top-level screen controller for the VGA path: decides which display ROM frame (title, in-game, end/victory) drives pixels.
- Brightness fades between scenes; scene changes only at frame boundaries, so no tearing.
- Latches the winner for the end-frame ROM's background colour and gates game logic.
- Sits between the game core/button debouncers and the frame-ROM mux feeding the VGA encoder.

Parameters:
- FADE_DIV, 4, frame ticks per fade level (must be >=1)
- END_MIN_FRAMES, 180, frame ticks the end screen is held before restart is accepted (>=1)
- BLINK_FRAMES, 32, frame ticks per half-period of the "press start" blink (>=1)

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_frame_tick  input  1  one-cycle pulse at start of vertical blank
- i_start  input  1  debounced start button, one-cycle pulse
- i_game_over  input  1  one-cycle pulse from game core
- i_p1_win  input  1  winner flag, valid when i_game_over=1
- o_scene  output  2  0=TITLE, 1=GAME, 2=END, 3 reserved (never driven)
- o_fade  output  3  dim level: 0 full brightness, 7 black
- o_is_p1_win  output  1  latched winner, to the end-frame ROM
- o_game_en  output  1  game core enable
- o_blink  output  1  prompt visibility on the end screen
- o_busy  output  1  high while a fade is in progress

Behaviour:
- All outputs registered.
- Reset (async assert, sync release) values:
  - state TITLE, o_scene=0, o_fade=0, o_is_p1_win=0, o_game_en=0, o_blink=0, o_busy=0.
  - All counters and pending flags cleared.
  - Reset mid-fade or mid-game returns to the same values immediately.
- Pending flags:
  - start_pend is set by i_start only in TITLE or END_READY; start pulses in any other state are dropped.
  - over_pend is set by i_game_over only in GAME.
  - A tick treats pend|pulse as the event, so a pulse coincident with i_frame_tick is consumed by that tick.
  - A flag clears when consumed or when the state is left.
- Winner latch: o_is_p1_win <= i_p1_win on any i_game_over accepted in GAME, visible the next cycle. It holds through END and the following TITLE until the next accepted game over.
- States (transitions evaluated only on cycles with i_frame_tick=1):
  - TITLE: scene 0, fade 0. start event -> FADE_OUT with target GAME.
  - GAME: scene 1, o_game_en=1. over event -> FADE_OUT with target END. o_game_en drops the cycle after leaving.
  - FADE_OUT: o_busy=1, scene unchanged.
    - Divider counts ticks 0..FADE_DIV-1; on wrap, o_fade increments.
    - When o_fade==7 and the divider wraps, o_scene <= target and the state moves to FADE_IN.
  - FADE_IN: o_busy=1. o_fade decrements on each divider wrap. Leaving the state at o_fade==0 after a wrap, the next state is:
    - GAME if target=GAME
    - END_SHOW if target=END
    - TITLE if target=TITLE
  - END_SHOW: scene 2, o_blink=0. Frame counter increments each tick; at END_MIN_FRAMES-1 -> END_READY, counter cleared.
  - END_READY: scene 2. o_blink toggles every BLINK_FRAMES ticks, first toggle to 1. start event -> FADE_OUT with target TITLE; o_blink forced to 0.
- Timing:
  - Full fade = 8*FADE_DIV ticks out + 8*FADE_DIV ticks in; scene switch lands exactly on the black frame.
  - Ticks less than 2 cycles apart are legal; each tick is one step.
- Counter widths: $clog2 of the parameter + 1; no overflow is reachable.

Decomposition:
- Shared package:
  - scene_t enum (TITLE, GAME, END)
  - state_t enum (TITLE, GAME, FADE_OUT, FADE_IN, END_SHOW, END_READY)
  - FADE_MAX=3'd7
- One sub-module: frame_tick_counter, a parameterised modulo-N counter advancing on i_frame_tick with a wrap pulse and synchronous clear. It is instantiated for the fade divider, the end hold and the blink.

Test Plan:
- Reset mid-FADE_OUT (o_fade=4): assert i_rst_n=0 -> o_scene=0, o_fade=0, o_busy=0, o_game_en=0 immediately.
- TITLE, i_start, then ticks (FADE_DIV=4):
  - o_fade reaches 7 after 28 ticks.
  - o_scene switches to 1 at tick 32.
  - o_fade returns to 0 and o_game_en=1 after tick 64.
- GAME: i_game_over with i_p1_win=1 in the same cycle as i_frame_tick -> o_is_p1_win=1 next cycle, fade-out starts on that tick, o_game_en=0, o_scene=2 after 32 ticks.
- END_SHOW: i_start before END_MIN_FRAMES ticks -> ignored. After 180 ticks -> END_READY; o_blink=1 after 32 more ticks, 0 after 64.
- END_READY: i_start -> fade to o_scene=0; o_is_p1_win stays 1. Next game over with i_p1_win=0 -> o_is_p1_win=0.
- i_game_over pulses in TITLE and in FADE_IN -> no state change, o_is_p1_win unchanged.
